// File: rtl/raptor64_wb_arb.sv
// raptor64_wb_arb: two-master round-robin WISHBONE arbiter with a stall watchdog.
// Ports: clk_i / rst_i (async, active-low); m0_* and m1_* are master-side WISHBONE
// ports; s_* is the shared slave port; gnt_o is the one-hot current owner.
module raptor64_wb_arb #(
  parameter logic [7:0] TMO = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [7:0]  m0_sel_i,
  input  logic [63:0] m0_adr_i,
  input  logic [63:0] m0_dat_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [63:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [7:0]  m1_sel_i,
  input  logic [63:0] m1_adr_i,
  input  logic [63:0] m1_dat_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [63:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [7:0]  s_sel_o,
  output logic [63:0] s_adr_o,
  output logic [63:0] s_dat_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic        s_ack_i,
  input  logic [63:0] s_dat_i,
  output logic [1:0]  gnt_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ERR} state_t;
  state_t r_state, w_next;
  logic r_last, r_err1;
  logic [7:0] r_wd;
  logic w_own0, w_own1, w_stall, w_cyc;
  assign w_own0 = r_state == OWN0;
  assign w_own1 = r_state == OWN1;
  assign w_stall = s_stb_o & ~s_ack_i;
  // r_last tracks the current owner throughout OWN and ERR, so it selects whose cyc ends the tenure
  assign w_cyc = r_last ? m1_cyc_i : m0_cyc_i;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = m0_cyc_i & (~m1_cyc_i | r_last) ? OWN0 : m1_cyc_i ? OWN1 : IDLE;
    else if (!w_cyc)
      w_next = IDLE;
    else if (r_state == ERR || (w_stall && r_wd == TMO))
      w_next = ERR;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wd    <= '0;
      r_err1  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_last  <= w_next == OWN0 ? 1'b0 : w_next == OWN1 ? 1'b1 : r_last;
      r_wd    <= (w_next != r_state || !w_stall) ? '0 : r_wd + 8'd1;
      r_err1  <= w_next == ERR && r_state != ERR;
    end
  end
  assign s_cyc_o  = w_own0 ? m0_cyc_i : w_own1 ? m1_cyc_i : 1'b0;
  assign s_stb_o  = w_own0 ? m0_stb_i : w_own1 ? m1_stb_i : 1'b0;
  assign s_we_o   = w_own0 ? m0_we_i  : w_own1 ? m1_we_i  : 1'b0;
  assign s_sel_o  = w_own0 ? m0_sel_i : w_own1 ? m1_sel_i : '0;
  assign s_adr_o  = w_own0 ? m0_adr_i : w_own1 ? m1_adr_i : '0;
  assign s_dat_o  = w_own0 ? m0_dat_i : w_own1 ? m1_dat_i : '0;
  assign s_cti_o  = w_own0 ? m0_cti_i : w_own1 ? m1_cti_i : '0;
  assign s_bte_o  = w_own0 ? m0_bte_i : w_own1 ? m1_bte_i : '0;
  assign m0_ack_o = w_own0 & s_ack_i & m0_stb_i;
  assign m1_ack_o = w_own1 & s_ack_i & m1_stb_i;
  assign m0_err_o = r_err1 & ~r_last;
  assign m1_err_o = r_err1 & r_last;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {w_own1, w_own0};
endmodule

// File: tb/tb_raptor64_wb_arb.sv
// tb_raptor64_wb_arb: vector table, directed corner cases and a random run against a tenure model.
module tb_raptor64_wb_arb;
  localparam logic [7:0] TMO = 8'd8;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [7:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [63:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic [2:0] m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0] m0_bte_i, m1_bte_i, s_bte_o, gnt_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [63:0] s_adr_o, s_dat_o, s_dat_i;
  int nerr = 0, nchk = 0;
  int m_owner, m_last, m_stall;
  bit m_on = 0, m_err, m_first;
  always #5 clk_i = ~clk_i;
  raptor64_wb_arb #(.TMO(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
  );
  typedef struct {
    logic c0, s0, c1, s1, ack;
    logic [1:0] gnt;
    logic scyc, a0, a1;
  } vec_t;
  vec_t vt[13];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic busy();
    return |{s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o, s_bte_o,
             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, gnt_o};
  endfunction
  task automatic clr();
    {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i, m0_cti_i, m0_bte_i} = '0;
    {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_cti_i, m1_bte_i} = '0;
    s_ack_i = 1'b0;
    s_dat_i = '0;
  endtask
  // Reference: a tenure belongs to one master until its cyc drops; a tenure with more
  // than TMO consecutive un-acked strobe cycles becomes an error tenure.
  task automatic model_edge();
    bit cy[2], st[2];
    cy[0] = m0_cyc_i; cy[1] = m1_cyc_i;
    st[0] = m0_stb_i; st[1] = m1_stb_i;
    if (m_err) begin
      m_first = 0;
      if (!cy[m_owner]) begin m_err = 0; m_owner = -1; end
    end else if (m_owner < 0) begin
      if (cy[0] || cy[1]) begin
        m_owner = (cy[0] && cy[1]) ? 1 - m_last : (cy[0] ? 0 : 1);
        m_last = m_owner;
        m_stall = 0;
      end
    end else if (!cy[m_owner]) m_owner = -1;
    else begin
      m_stall = (st[m_owner] && !s_ack_i) ? m_stall + 1 : 0;
      if (m_stall > int'(TMO)) begin m_err = 1; m_first = 1; end
    end
  endtask
  task automatic model_check();
    logic [15:0] ectl;
    logic [63:0] eadr, edat;
    logic [1:0] egnt;
    logic [3:0] eae;
    bit live;
    live = m_owner >= 0 && !m_err;
    ectl = '0; eadr = '0; edat = '0;
    if (live && m_owner == 0) begin
      ectl = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_cti_i, m0_bte_i};
      eadr = m0_adr_i; edat = m0_dat_i;
    end
    if (live && m_owner == 1) begin
      ectl = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_cti_i, m1_bte_i};
      eadr = m1_adr_i; edat = m1_dat_i;
    end
    egnt = !live ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
    eae = {live && m_owner == 0 && s_ack_i && m0_stb_i, live && m_owner == 1 && s_ack_i && m1_stb_i,
           m_err && m_first && m_owner == 0, m_err && m_first && m_owner == 1};
    chk("rnd_gnt", gnt_o, egnt);
    chk("rnd_sctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_cti_o, s_bte_o}, ectl);
    chk("rnd_sadr", s_adr_o, eadr);
    chk("rnd_sdat", s_dat_o, edat);
    chk("rnd_ackerr", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, eae);
    chk("rnd_m0dat", m0_dat_o, s_dat_i);
    chk("rnd_m1dat", m1_dat_o, s_dat_i);
  endtask
  task automatic tick();
    @(posedge clk_i);
    if (m_on) model_edge();
    #1;
  endtask
  task automatic settle();
    #4;
  endtask
  initial begin
    int ack_pct;
    vt[0]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
    vt[1]  = '{1, 1, 1, 1, 1, 2'b01, 1, 1, 0};
    vt[2]  = '{0, 0, 1, 1, 1, 2'b01, 0, 0, 0};
    vt[3]  = '{0, 0, 1, 1, 1, 2'b00, 0, 0, 0};
    vt[4]  = '{1, 1, 1, 1, 1, 2'b10, 1, 0, 1};
    vt[5]  = '{1, 1, 0, 0, 0, 2'b10, 0, 0, 0};
    vt[6]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
    vt[7]  = '{1, 1, 1, 1, 1, 2'b01, 1, 1, 0};
    vt[8]  = '{0, 0, 1, 1, 0, 2'b01, 0, 0, 0};
    vt[9]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
    vt[10] = '{0, 0, 1, 1, 1, 2'b10, 1, 0, 1};
    vt[11] = '{0, 0, 0, 0, 0, 2'b10, 0, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0};
    clr();
    rst_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("idle_zero", busy(), 1'b0);
      tick();
    end
    for (int i = 0; i < 13; i++) begin
      m0_cyc_i = vt[i].c0; m0_stb_i = vt[i].s0;
      m1_cyc_i = vt[i].c1; m1_stb_i = vt[i].s1;
      s_ack_i = vt[i].ack;
      settle();
      chk("tab_gnt", gnt_o, vt[i].gnt);
      chk("tab_scyc", s_cyc_o, vt[i].scyc);
      chk("tab_ack", {m0_ack_o, m1_ack_o}, {vt[i].a0, vt[i].a1});
      chk("tab_err", {m0_err_o, m1_err_o}, 2'b00);
      tick();
    end
    clr();
    m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 8'hFF; m0_adr_i = 64'hFFFFFFFFFFFFF000;
    s_ack_i = 1; s_dat_i = 64'h00001CA1FFD00000;
    settle();
    chk("rd_latency_cyc", s_cyc_o, 1'b0);
    chk("rd_latency_ack", m0_ack_o, 1'b0);
    tick();
    settle();
    chk("rd_cyc", s_cyc_o, 1'b1);
    chk("rd_adr", s_adr_o, 64'hFFFFFFFFFFFFF000);
    chk("rd_we", s_we_o, 1'b0);
    chk("rd_ack0", m0_ack_o, 1'b1);
    chk("rd_dat0", m0_dat_o, 64'h00001CA1FFD00000);
    chk("rd_ack1", m1_ack_o, 1'b0);
    chk("rd_gnt", gnt_o, 2'b01);
    clr();
    tick();
    settle();
    chk("rd_release", gnt_o, 2'b00);
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 8'h0F; m1_cti_i = 3'b010; m1_bte_i = 2'b00;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1;
    s_ack_i = 1;
    for (int b = 0; b < 4; b++) begin
      m1_cti_i = b == 3 ? 3'b111 : 3'b010;
      m1_adr_i = 64'h1000 + 64'(8 * b);
      m1_dat_i = 64'hA5A5_0000_0000_0000 + 64'(b);
      settle();
      chk("burst_gnt", gnt_o, 2'b10);
      chk("burst_cti", s_cti_o, b == 3 ? 3'b111 : 3'b010);
      chk("burst_adr", s_adr_o, 64'h1000 + 64'(8 * b));
      chk("burst_ack", {m0_ack_o, m1_ack_o}, 2'b01);
      tick();
    end
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    settle();
    chk("burst_drop_cyc", s_cyc_o, 1'b0);
    tick();
    settle();
    chk("burst_gap", gnt_o, 2'b00);
    tick();
    settle();
    chk("burst_handover", gnt_o, 2'b01);
    chk("burst_handover_cyc", s_cyc_o, 1'b1);
    clr();
    tick();
    m0_cyc_i = 1;
    tick();
    m0_stb_i = 1;
    for (int k = 0; k < 14; k++) begin
      settle();
      chk("wd_err0", m0_err_o, k == 9);
      chk("wd_err1", m1_err_o, 1'b0);
      chk("wd_scyc", s_cyc_o, k < 9);
      tick();
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    settle();
    chk("wd_err_hold", s_cyc_o, 1'b0);
    tick();
    settle();
    chk("wd_back_idle", busy(), 1'b0);
    tick();
    m0_cyc_i = 1;
    tick();
    m0_stb_i = 1;
    for (int k = 0; k < 9; k++) begin
      s_ack_i = k == 8;
      settle();
      chk("dl_ack", m0_ack_o, k == 8);
      chk("dl_err", m0_err_o, 1'b0);
      tick();
    end
    s_ack_i = 0; m0_stb_i = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("dl_noerr", m0_err_o, 1'b0);
      chk("dl_still_own", s_cyc_o, 1'b1);
      tick();
    end
    m0_stb_i = 1;
    settle();
    chk("rst_pre", gnt_o, 2'b01);
    #1 rst_i = 1'b0;
    #1 chk("rst_async", busy(), 1'b0);
    tick();
    clr();
    rst_i = 1'b1;
    m_owner = -1; m_last = 1; m_stall = 0; m_err = 0; m_first = 0; m_on = 1;
    ack_pct = 60;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) ack_pct = ($urandom % 3 == 0) ? 0 : 60;
      m0_cyc_i = m0_cyc_i ? ($urandom % 10 != 0) : ($urandom % 4 == 0);
      m1_cyc_i = m1_cyc_i ? ($urandom % 10 != 0) : ($urandom % 4 == 0);
      m0_stb_i = m0_cyc_i & ($urandom % 4 != 0);
      m1_stb_i = m1_cyc_i & ($urandom % 4 != 0);
      m0_we_i = 1'($urandom); m0_sel_i = 8'($urandom); m0_cti_i = 3'($urandom); m0_bte_i = 2'($urandom);
      m1_we_i = 1'($urandom); m1_sel_i = 8'($urandom); m1_cti_i = 3'($urandom); m1_bte_i = 2'($urandom);
      m0_adr_i = {$urandom, $urandom}; m0_dat_i = {$urandom, $urandom};
      m1_adr_i = {$urandom, $urandom}; m1_dat_i = {$urandom, $urandom};
      s_ack_i = int'($urandom_range(99, 0)) < ack_pct;
      s_dat_i = {$urandom, $urandom};
      settle();
      model_check();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
